// File: rtl/cpu_pkg.sv
// Shared fetch-stage types and constants: opcode, widths, FSM encoding and queue entry layout.
package cpu_pkg;

    localparam int          INSTR_W = 16;
    localparam logic [3:0]  OPC_HLT = 4'hF;
    localparam logic [15:0] PC_INC  = 16'd2;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        WAIT   = 2'd1,
        SQUASH = 2'd2,
        HALTED = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [15:0]        pc_inc;
    } fq_entry_t;

    function automatic logic is_hlt(input logic [INSTR_W-1:0] word);
        return word[INSTR_W-1 -: 4] == OPC_HLT;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response channel between the fetch unit (master) and imem (slave).
interface fetch_unit_if;
    import cpu_pkg::*;

    logic               imem_req;
    logic [15:0]        imem_addr;
    logic               imem_gnt;
    logic               imem_rvalid;
    logic [INSTR_W-1:0] imem_rdata;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata
    );

endinterface

// File: rtl/dff.sv
// Generic register cell with asynchronous active-high reset to a parameterised value.
module dff #(
    parameter int           W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) q <= RST_VAL;
        else     q <= d;
    end

endmodule

// File: rtl/fetch_queue.sv
// Circular fetch FIFO of {instr, pc+2} entries; pointers carry a wrap bit so full/empty need no counter.
module fetch_queue
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      flush,
    input  logic      wr_en,
    input  fq_entry_t wr_data,
    input  logic      rd_en,
    output fq_entry_t rd_data,
    output logic      empty,
    output logic      full
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        do_wr, do_rd;
    fq_entry_t   mem_q [DEPTH];

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // A read frees the head slot in the same cycle, so a write at full is legal alongside it.
    assign do_rd = rd_en && !empty && !flush;
    assign do_wr = wr_en && (!full || do_rd) && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_wr};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_rd};
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end

    assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues single-outstanding imem reads, buffers returned words,
// handles branch redirects (squashing a read in flight) and stops after an HLT word.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int          DEPTH    = 2,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               branch,
    input  logic [15:0]        pcBranch,
    fetch_unit_if.master       imem,
    output logic [INSTR_W-1:0] instr,
    output logic [15:0]        pcInc,
    output logic               instr_valid,
    output logic               fetch_halted
);

    fetch_state_e state_q, state_d;
    logic [1:0]   state_bits_q;
    logic [15:0]  pc_q, pc_d;
    logic         handshake;
    logic         fq_wr_en, fq_rd_en, fq_empty, fq_full;
    fq_entry_t    fq_wr_data, fq_rd_data;
    logic         unused_pc_lsb;

    assign unused_pc_lsb = pcBranch[0];

    dff #(.W(2), .RST_VAL(FETCH)) u_state_reg (
        .clk (clk),
        .rst (rst),
        .d   (state_d),
        .q   (state_bits_q)
    );
    assign state_q = fetch_state_e'(state_bits_q);

    dff #(.W(16), .RST_VAL(RESET_PC)) u_pc_reg (
        .clk (clk),
        .rst (rst),
        .d   (pc_d),
        .q   (pc_q)
    );

    assign handshake = imem.imem_req && imem.imem_gnt;

    // Next state; a redirect wins over everything and turns a still-pending read into a squash.
    always_comb begin
        state_d = state_q;
        if (branch) begin
            case (state_q)
                WAIT, SQUASH: state_d = imem.imem_rvalid ? FETCH : SQUASH;
                default:      state_d = FETCH;
            endcase
        end else begin
            case (state_q)
                FETCH:   if (handshake) state_d = WAIT;
                WAIT:    if (imem.imem_rvalid) state_d = is_hlt(imem.imem_rdata) ? HALTED : FETCH;
                SQUASH:  if (imem.imem_rvalid) state_d = FETCH;
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        pc_d = pc_q;
        if (branch)         pc_d = {pcBranch[15:1], 1'b0};
        else if (handshake) pc_d = pc_q + PC_INC;
    end

    // The PC already points past the outstanding read, so it is the pc+2 recorded with the word.
    always_comb begin
        imem.imem_req  = (state_q == FETCH) && !fq_full && !branch && !rst;
        imem.imem_addr = pc_q;
        fq_wr_en       = (state_q == WAIT) && imem.imem_rvalid && !branch;
        fq_wr_data     = '{instr: imem.imem_rdata, pc_inc: pc_q};
        fq_rd_en       = !stall;
        instr_valid    = !fq_empty;
        instr          = fq_empty ? '0 : fq_rd_data.instr;
        pcInc          = fq_empty ? '0 : fq_rd_data.pc_inc;
        fetch_halted   = (state_q == HALTED);
    end

    fetch_queue #(.DEPTH(DEPTH)) u_queue (
        .clk     (clk),
        .rst     (rst),
        .flush   (branch),
        .wr_en   (fq_wr_en),
        .wr_data (fq_wr_data),
        .rd_en   (fq_rd_en),
        .rd_data (fq_rd_data),
        .empty   (fq_empty),
        .full    (fq_full)
    );

    // Read data is only legal while a read is outstanding (live or squashed).
    a_rvalid_outstanding: assert property (@(posedge clk) disable iff (rst)
        imem.imem_rvalid |-> (state_q == WAIT || state_q == SQUASH));

endmodule
